onehot_pulse_decoder: RTL

Registered 3-to-8 decoder, the inverse of the 8:3 priority encoder. It accepts a 3-bit code over a valid/ready handshake and drives the matching one-hot line on d_out for a fixed PULSE_LEN cycles. It then enforces a GAP_LEN-cycle quiet gap before it accepts the next code. It sits downstream of the priority encoder and regenerates a single clean strobe line from an encoded request.

---
 rtl/onehot_pulse_decoder.sv | 112 +++++++++++
 1 files changed

// File: rtl/onehot_pulse_decoder.sv
// Registered 3-to-8 decoder: an accepted code drives one d_out line for PULSE_LEN cycles, then a GAP_LEN quiet gap.
// Outputs change one cycle after the accepting edge; code_ready is low in DRIVE/GAP and codes offered then are dropped.
module onehot_pulse_decoder #(
    parameter int unsigned PULSE_LEN = 4,
    parameter int unsigned GAP_LEN   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] code_in,
    input  logic       code_valid,
    output logic       code_ready,
    output logic [7:0] d_out,
    output logic       busy,
    output logic       done,
    output logic [2:0] last_code
);

    if (PULSE_LEN == 0 || PULSE_LEN > 255 || GAP_LEN > 255) begin : g_param_check
        $fatal(1, "onehot_pulse_decoder: PULSE_LEN must be 1..255 and GAP_LEN 0..255");
    end

    localparam logic [7:0] PULSE_LAST = 8'(PULSE_LEN - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] d_out_q, d_out_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [2:0] last_code_q, last_code_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        d_out_d     = d_out_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        last_code_d = last_code_q;
        case (state_q)
            IDLE: begin
                if (code_valid) begin
                    d_out_d     = 8'd1 << code_in;
                    last_code_d = code_in;
                    cnt_d       = PULSE_LAST;
                    state_d     = DRIVE;
                    busy_d      = 1'b1;
                end
            end
            DRIVE: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    d_out_d = 8'd0;
                    done_d  = 1'b1;
                    // With no gap configured the block drops straight back to IDLE.
                    if (GAP_LEN != 0) begin
                        state_d = GAP;
                        cnt_d   = GAP_LAST;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            GAP: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                d_out_d = 8'd0;
                busy_d  = 1'b0;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            d_out_q     <= 8'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            last_code_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            d_out_q     <= d_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            last_code_q <= last_code_d;
        end
    end

    assign code_ready = (state_q == IDLE);
    assign d_out      = d_out_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign last_code  = last_code_q;

endmodule
